// File: rtl/config_loader.sv
// config_loader: streams a bitstream into two serial scan chains, first the
// CLB chain and then the connection chain.
//
// Words arrive over a valid/ready handshake. Each accepted word is shifted
// out LSB first, one bit per cycle, onto the active chain's scan_in with
// scan_en high. The word buffer refills with exactly one idle cycle per word.
// When a chain reaches its length, the unused upper bits of the current word
// are dropped, and the next chain starts from a fresh word.
//
// Optional feature macro: CFG_READBACK_EN. When it is defined, the active
// chain's scan_out is captured on every shift cycle and packed LSB first into
// rb_data. rb_valid pulses after each full word, or at chain end with the
// upper bits zero. When it is undefined, rb_data and rb_valid are tied to 0.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      begin a pass (honoured in IDLE/DONE only)
//   in_data, in_valid/in_ready bitstream word handshake
//   clb_scan_in/en/out         CLB chain serial interface
//   conn_scan_in/en/out        connection chain serial interface
//   busy, done                 pass status
//   rb_data, rb_valid          readback word (CFG_READBACK_EN only)
module config_loader #(
  parameter int unsigned CLB_CHAIN_LEN  = 16,
  parameter int unsigned CONN_CHAIN_LEN = 48,
  parameter int unsigned WORD_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  clb_scan_in,
  output logic                  clb_scan_en,
  input  logic                  clb_scan_out,
  output logic                  conn_scan_in,
  output logic                  conn_scan_en,
  input  logic                  conn_scan_out,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid
);

  localparam int unsigned MaxLen = (CLB_CHAIN_LEN > CONN_CHAIN_LEN) ? CLB_CHAIN_LEN
                                                                     : CONN_CHAIN_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);
  localparam int unsigned RemW   = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StLoadClb, StLoadConn, StDone} state_e;

  state_e                state_q;
  logic [WORD_WIDTH-1:0] word_q;     // bits of the current word not yet shifted
  logic [RemW-1:0]       rem_q;      // count of bits left in word_q
  logic [CntW-1:0]       bit_cnt_q;  // bits issued on the active chain
  logic                  in_ready_q;
  logic                  clb_scan_in_q, clb_scan_en_q;
  logic                  conn_scan_in_q, conn_scan_en_q;
  logic                  busy_q, done_q;

  logic            in_clb;
  logic [CntW-1:0] chain_len;
  logic            shifting;
  logic            chain_last;
  logic            from_buf;
  logic            take_word;
  logic            emit_bit;

  assign in_clb    = (state_q == StLoadClb);
  assign chain_len = in_clb ? CntW'(CLB_CHAIN_LEN) : CntW'(CONN_CHAIN_LEN);
  assign shifting  = clb_scan_en_q | conn_scan_en_q;
  // The bit on scan_in this cycle is the chain's final one.
  assign chain_last = shifting && (bit_cnt_q == chain_len);
  assign from_buf   = (rem_q != '0);
  assign take_word  = in_ready_q & in_valid;
  assign emit_bit   = from_buf ? word_q[0] : in_data[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      word_q         <= '0;
      rem_q          <= '0;
      bit_cnt_q      <= '0;
      in_ready_q     <= 1'b0;
      clb_scan_in_q  <= 1'b0;
      clb_scan_en_q  <= 1'b0;
      conn_scan_in_q <= 1'b0;
      conn_scan_en_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StLoadClb;
            bit_cnt_q  <= '0;
            rem_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        StLoadClb, StLoadConn: begin
          if (chain_last) begin
            // The chain is full, so any leftover bits of the word are dropped.
            clb_scan_in_q  <= 1'b0;
            clb_scan_en_q  <= 1'b0;
            conn_scan_in_q <= 1'b0;
            conn_scan_en_q <= 1'b0;
            rem_q          <= '0;
            bit_cnt_q      <= '0;
            if (in_clb) begin
              state_q    <= StLoadConn;
              in_ready_q <= 1'b1;
            end else begin
              state_q    <= StDone;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end else if (from_buf || take_word) begin
            clb_scan_in_q  <= in_clb & emit_bit;
            clb_scan_en_q  <= in_clb;
            conn_scan_in_q <= ~in_clb & emit_bit;
            conn_scan_en_q <= ~in_clb;
            bit_cnt_q      <= bit_cnt_q + CntW'(1);
            in_ready_q     <= 1'b0;
            if (from_buf) begin
              word_q <= word_q >> 1;
              rem_q  <= rem_q - RemW'(1);
            end else begin
              word_q <= in_data >> 1;
              rem_q  <= RemW'(WORD_WIDTH - 1);
            end
          end else begin
            // The buffer is drained: this is the one idle cycle per word, or starvation.
            clb_scan_in_q  <= 1'b0;
            clb_scan_en_q  <= 1'b0;
            conn_scan_in_q <= 1'b0;
            conn_scan_en_q <= 1'b0;
            in_ready_q     <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign clb_scan_in  = clb_scan_in_q;
  assign clb_scan_en  = clb_scan_en_q;
  assign conn_scan_in = conn_scan_in_q;
  assign conn_scan_en = conn_scan_en_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef CFG_READBACK_EN
  localparam int unsigned RbW = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] rb_acc_q;
  logic [WORD_WIDTH-1:0] rb_data_q;
  logic [RbW-1:0]        rb_idx_q;
  logic                  rb_valid_q;
  logic                  cap_bit;
  logic [WORD_WIDTH-1:0] rb_merged;

  assign cap_bit   = clb_scan_en_q ? clb_scan_out : conn_scan_out;
  assign rb_merged = rb_acc_q | (WORD_WIDTH'(cap_bit) << rb_idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_acc_q   <= '0;
      rb_data_q  <= '0;
      rb_idx_q   <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (shifting) begin
        if ((rb_idx_q == RbW'(WORD_WIDTH - 1)) || chain_last) begin
          rb_data_q  <= rb_merged;
          rb_valid_q <= 1'b1;
          rb_acc_q   <= '0;
          rb_idx_q   <= '0;
        end else begin
          rb_acc_q <= rb_merged;
          rb_idx_q <= rb_idx_q + RbW'(1);
        end
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_scan_out;
  assign unused_scan_out = clb_scan_out ^ conn_scan_out;
  assign rb_data         = '0;
  assign rb_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader (CLB=10, CONN=6, WORD=8). The driver
// pushes hand-computed chain bits into per-chain queues. A negedge monitor
// pops from a queue and compares whenever a scan_en is high.
module tb_config_loader;

  localparam int unsigned ClbLen  = 10;
  localparam int unsigned ConnLen = 6;
  localparam int unsigned Ww      = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [Ww-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          clb_scan_in, clb_scan_en;
  logic          clb_scan_out = 1'b1;
  logic          conn_scan_in, conn_scan_en;
  logic          conn_scan_out = 1'b0;
  logic          busy, done;
  logic [Ww-1:0] rb_data;
  logic          rb_valid;

  int checks = 0;
  int errors = 0;
  int clb_seen = 0;

  logic          clb_q[$];
  logic          conn_q[$];
  logic [Ww-1:0] rb_q[$];

  config_loader #(
    .CLB_CHAIN_LEN (ClbLen),
    .CONN_CHAIN_LEN(ConnLen),
    .WORD_WIDTH    (Ww)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .clb_scan_in  (clb_scan_in),
    .clb_scan_en  (clb_scan_en),
    .clb_scan_out (clb_scan_out),
    .conn_scan_in (conn_scan_in),
    .conn_scan_en (conn_scan_en),
    .conn_scan_out(conn_scan_out),
    .busy         (busy),
    .done         (done),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: decoupled from stimulus, compares against queued expectations.
  always @(negedge clk) begin
    if (clb_scan_en || conn_scan_en)
      check("scan_en_exclusive", 32'(clb_scan_en & conn_scan_en), 32'd0);
    if (!clb_scan_en) begin
      if (clb_scan_in !== 1'b0) check("clb_scan_in_idle", 32'(clb_scan_in), 32'd0);
    end else begin
      clb_seen++;
      if (clb_q.size() == 0) check("clb_extra_shift", 32'd1, 32'd0);
      else check("clb_bit", 32'(clb_scan_in), 32'(clb_q.pop_front()));
    end
    if (!conn_scan_en) begin
      if (conn_scan_in !== 1'b0) check("conn_scan_in_idle", 32'(conn_scan_in), 32'd0);
    end else begin
      if (conn_q.size() == 0) check("conn_extra_shift", 32'd1, 32'd0);
      else check("conn_bit", 32'(conn_scan_in), 32'(conn_q.pop_front()));
    end
    if (rb_valid) begin
      if (rb_q.size() == 0) check("rb_valid_unexpected", 32'(rb_valid), 32'd0);
      else check("rb_data", 32'(rb_data), 32'(rb_q.pop_front()));
    end
  end

  task automatic push_clb(input logic [Ww-1:0] w, input int n);
    for (int i = 0; i < n; i++) clb_q.push_back(w[i]);
  endtask

  task automatic push_conn(input logic [Ww-1:0] w, input int n);
    for (int i = 0; i < n; i++) conn_q.push_back(w[i]);
  endtask

  // Expected stream for words A5, 03, 3C: CLB 1,0,1,0,0,1,0,1,1,1 and CONN 0,0,1,1,1,1.
  task automatic push_std_pass();
    push_clb(8'hA5, 8);
    push_clb(8'h03, 2);
    push_conn(8'h3C, 6);
`ifdef CFG_READBACK_EN
    rb_q.push_back(8'hFF);  // 8 CLB captures of 1
    rb_q.push_back(8'h03);  // chain end after 2 more
    rb_q.push_back(8'h00);  // 6 CONN captures of 0
`endif
  endtask

  // Called at a negedge and returns at the negedge after acceptance.
  task automatic send(input logic [Ww-1:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Starve the loader for 5 cycles once the buffer has drained.
  task automatic starve();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("starve_scan_en", 32'({clb_scan_en, conn_scan_en}), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("clb_queue_drained", 32'(clb_q.size()), 32'd0);
    check("conn_queue_drained", 32'(conn_q.size()), 32'd0);
    check("rb_queue_drained", 32'(rb_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 32'({in_ready, clb_scan_in, clb_scan_en, conn_scan_in,
                               conn_scan_en, busy, done, rb_valid}), 32'd0);
    check({tag, "_rb_data"}, 32'(rb_data), 32'd0);
  endtask

  initial begin
    int base;
    // Reset has priority over a simultaneous start.
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Back-to-back words.
    push_std_pass();
    pulse_start();
    send(8'hA5);
    send(8'h03);
    send(8'h3C);
    wait_done();

    // Starvation between words; restart from DONE.
    push_std_pass();
    pulse_start();
    send(8'hA5);
    starve();
    send(8'h03);
    starve();
    send(8'h3C);
    wait_done();

    // start during LOAD_CLB is ignored.
    push_std_pass();
    pulse_start();
    send(8'hA5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_ignored_busy", 32'(busy), 32'd1);
    send(8'h03);
    send(8'h3C);
    wait_done();

    // Reset after 4 CLB bits aborts the pass.
    push_clb(8'hA5, 8);
    pulse_start();
    base = clb_seen;
    send(8'hA5);
    while (clb_seen - base < 4) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("abort");
    clb_q.delete();
    conn_q.delete();
    rst = 1'b0;
    @(negedge clk);

    // A fresh pass reloads all 10 bits.
    push_std_pass();
    pulse_start();
    send(8'hA5);
    send(8'h03);
    send(8'h3C);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
